// File: rtl/f_u_rca3_reg.sv
// f_u_rca3_reg: registered flat 3-bit ripple-carry adder, out = a + b with carry-out in out[3].
// Define F_U_RCA3_INREG_EN to register a and b first, which makes the latency 2 cycles instead of 1.
module f_u_rca3_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [3:0] out
);
  logic [2:0] w_a, w_b, w_s, w_c;
`ifdef F_U_RCA3_INREG_EN
  logic [2:0] r_a, r_b;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= 3'd0;
      r_b <= 3'd0;
    end else begin
      r_a <= a;
      r_b <= b;
    end
  end
  assign w_a = r_a;
  assign w_b = r_b;
`else
  assign w_a = a;
  assign w_b = b;
`endif
  assign w_s[0] = w_a[0] ^ w_b[0];
  assign w_c[0] = w_a[0] & w_b[0];
  assign w_s[1] = w_a[1] ^ w_b[1] ^ w_c[0];
  assign w_c[1] = (w_a[1] & w_b[1]) | ((w_a[1] ^ w_b[1]) & w_c[0]);
  assign w_s[2] = w_a[2] ^ w_b[2] ^ w_c[1];
  assign w_c[2] = (w_a[2] & w_b[2]) | ((w_a[2] ^ w_b[2]) & w_c[1]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= 4'd0;
    else        out <= {w_c[2], w_s};
  end
endmodule

// File: tb/tb_f_u_rca3_reg.sv
// tb_f_u_rca3_reg: scoreboard bench; a per-edge model queues expected sums, a negedge monitor checks them.
module tb_f_u_rca3_reg;
`ifdef F_U_RCA3_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] a = 3'd5, b = 3'd6;
  logic [3:0] out;
  int         tests = 0, fails = 0;
  int         hist[$];
  logic [3:0] exp_q[$];

  f_u_rca3_reg dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .out(out));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: out=%0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: the sum of the operands seen LAT edges ago since reset release, else 0.
  always @(negedge rst_n) hist.delete();
  always @(posedge clk) begin
    if (!rst_n) exp_q.push_back(4'd0);
    else begin
      hist.push_back(int'(a) + int'(b));
      exp_q.push_back(hist.size() >= LAT ? 4'(hist[hist.size() - LAT]) : 4'd0);
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) chk("scoreboard", out, exp_q.pop_front());
  end

  task automatic apply(input int x, input int y);
    @(negedge clk);
    #2;
    a = 3'(x);
    b = 3'(y);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk("async_reset", out, 4'd0);
    repeat (3) apply(5, 6);
    @(negedge clk);
    #2 rst_n = 1'b1;
    a = 3'd0;
    b = 3'd2;
    apply(0, 2);
    apply(7, 1);
    apply(3, 1);
    apply(7, 7);
    apply(4, 4);
    apply(0, 0);
    for (int i = 0; i < 16; i++) apply(i % 8, (2 + i / 2) % 8);
    for (int i = 0; i < 64; i++) apply(i / 8, i % 8);
    for (int i = 0; i < 40; i++) apply(int'($urandom_range(7)), int'($urandom_range(7)));
    repeat (3) apply(6, 5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midop_reset", out, 4'd0);
    repeat (2) apply(6, 5);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (LAT + 3) apply(6, 5);
    apply(7, 7);
    repeat (LAT + 2) @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
